// File: rtl/dma_regrw_mc.sv
// DMA channel status poller with a single AXI4-Lite master.
// Rising edges on the run vector queue status reads, which are granted
// round-robin. A level-held write request takes priority over queued reads.
// Only one AXI transaction is in flight at any time.
module dma_regrw_mc #(
    parameter int         NUM_CHN  = 4,
    parameter logic [7:0] STTS_OFS = 8'h40
) (
    input  logic                   usr_clk,
    input  logic                   usr_rst,
    // AXI4-Lite master
    output logic [31:0]            s_axil_awaddr,
    output logic [2:0]             s_axil_awprot,
    output logic                   s_axil_awvalid,
    input  logic                   s_axil_awready,
    output logic [31:0]            s_axil_wdata,
    output logic [3:0]             s_axil_wstrb,
    output logic                   s_axil_wvalid,
    input  logic                   s_axil_wready,
    input  logic [1:0]             s_axil_bresp,
    input  logic                   s_axil_bvalid,
    output logic                   s_axil_bready,
    output logic [31:0]            s_axil_araddr,
    output logic [2:0]             s_axil_arprot,
    output logic                   s_axil_arvalid,
    input  logic                   s_axil_arready,
    input  logic [31:0]            s_axil_rdata,
    input  logic [1:0]             s_axil_rresp,
    input  logic                   s_axil_rvalid,
    output logic                   s_axil_rready,
    // Status read requests and results
    input  logic [2*NUM_CHN-1:0]   dma_regrw_run_i,
    input  logic                   wr_req_i,
    input  logic [15:0]            wr_addr_i,
    input  logic [31:0]            wr_data_i,
    output logic                   wr_done_o,
    output logic [NUM_CHN*32-1:0]  c2h_chn_stts_o,
    output logic [NUM_CHN*32-1:0]  h2c_chn_stts_o,
    output logic [2*NUM_CHN-1:0]   stts_upd_o,
    output logic [2*NUM_CHN:0]     resp_err_o
);

    localparam int NR = 2 * NUM_CHN;
    localparam int IW = $clog2(NR);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B} state_t;

    state_t        state;
    logic [NR-1:0] run_d1;
    logic [NR-1:0] pend;
    logic [NR-1:0] pend_nxt;
    logic [NR-1:0] rise;
    logic [NR-1:0] nxt_mask;
    logic [NR-1:0] gnt_mask;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt;
    logic [IW-1:0] gnt_nxt;
    logic          gnt_hit;
    logic          is_c2h;
    logic [3:0]    chn_nxt;
    logic [31:0]   rd_addr;
    logic          aw_done;
    logic          w_done;

    assign rise          = dma_regrw_run_i & ~run_d1;
    assign nxt_mask      = NR'(1) << gnt_nxt;
    assign gnt_mask      = NR'(1) << gnt;
    assign s_axil_arprot = 3'b000;
    assign s_axil_awprot = 3'b000;
    // A channel counts as finished once its valid is down or is handshaking now
    assign aw_done       = !s_axil_awvalid || s_axil_awready;
    assign w_done        = !s_axil_wvalid || s_axil_wready;

    // Round-robin search: first pending bit at or above the pointer, else wrap to the lowest
    always_comb begin
        gnt_hit = 1'b0;
        gnt_nxt = '0;
        for (int j = 0; j < NR; j++) begin
            if (!gnt_hit && pend[j] && (j >= int'(ptr))) begin
                gnt_hit = 1'b1;
                gnt_nxt = IW'(j);
            end
        end
        for (int j = 0; j < NR; j++) begin
            if (!gnt_hit && pend[j]) begin
                gnt_hit = 1'b1;
                gnt_nxt = IW'(j);
            end
        end
    end

    // Status register address of the candidate grant: low half is C2H, high half is H2C
    always_comb begin
        is_c2h  = int'(gnt_nxt) < NUM_CHN;
        chn_nxt = is_c2h ? 4'(gnt_nxt) : 4'(int'(gnt_nxt) - NUM_CHN);
        rd_addr = {16'd0, (is_c2h ? 4'h1 : 4'h0), chn_nxt, STTS_OFS};
    end

    // Pending bitmap: a grant clears its bit, a new edge (even on the serviced bit) re-arms it
    always_comb begin
        pend_nxt = pend;
        if (state == S_IDLE && !wr_req_i && gnt_hit) begin
            pend_nxt = pend & ~nxt_mask;
        end
        pend_nxt = pend_nxt | rise;
    end

    // Transaction FSM with registered AXI handshakes, status capture and error flags
    always_ff @(posedge usr_clk) begin
        if (usr_rst) begin
            state          <= S_IDLE;
            run_d1         <= '0;
            pend           <= '0;
            ptr            <= '0;
            gnt            <= '0;
            s_axil_awaddr  <= '0;
            s_axil_awvalid <= 1'b0;
            s_axil_wdata   <= '0;
            s_axil_wstrb   <= '0;
            s_axil_wvalid  <= 1'b0;
            s_axil_bready  <= 1'b0;
            s_axil_araddr  <= '0;
            s_axil_arvalid <= 1'b0;
            s_axil_rready  <= 1'b0;
            wr_done_o      <= 1'b0;
            c2h_chn_stts_o <= '0;
            h2c_chn_stts_o <= '0;
            stts_upd_o     <= '0;
            resp_err_o     <= '0;
        end else begin
            run_d1     <= dma_regrw_run_i;
            pend       <= pend_nxt;
            stts_upd_o <= '0;
            wr_done_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_req_i) begin
                        state          <= S_AW_W;
                        s_axil_awaddr  <= {16'd0, wr_addr_i};
                        s_axil_wdata   <= wr_data_i;
                        s_axil_wstrb   <= 4'hf;
                        s_axil_awvalid <= 1'b1;
                        s_axil_wvalid  <= 1'b1;
                    end else if (gnt_hit) begin
                        state          <= S_AR;
                        gnt            <= gnt_nxt;
                        ptr            <= (gnt_nxt == IW'(NR - 1)) ? '0 : gnt_nxt + 1'b1;
                        s_axil_araddr  <= rd_addr;
                        s_axil_arvalid <= 1'b1;
                    end
                end
                S_AR: begin
                    if (s_axil_arready) begin
                        state          <= S_R;
                        s_axil_arvalid <= 1'b0;
                        s_axil_rready  <= 1'b1;
                    end
                end
                S_R: begin
                    if (s_axil_rvalid) begin
                        state         <= S_IDLE;
                        s_axil_rready <= 1'b0;
                        stts_upd_o    <= gnt_mask;
                        for (int c = 0; c < NUM_CHN; c++) begin
                            if (gnt == IW'(c)) begin
                                c2h_chn_stts_o[32*c +: 32] <= s_axil_rdata;
                            end
                            if (gnt == IW'(c + NUM_CHN)) begin
                                h2c_chn_stts_o[32*c +: 32] <= s_axil_rdata;
                            end
                        end
                        if (s_axil_rresp != 2'b00) begin
                            resp_err_o[NR-1:0] <= resp_err_o[NR-1:0] | gnt_mask;
                        end
                    end
                end
                S_AW_W: begin
                    if (s_axil_awvalid && s_axil_awready) begin
                        s_axil_awvalid <= 1'b0;
                    end
                    if (s_axil_wvalid && s_axil_wready) begin
                        s_axil_wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        state         <= S_B;
                        s_axil_bready <= 1'b1;
                    end
                end
                S_B: begin
                    if (s_axil_bvalid) begin
                        state         <= S_IDLE;
                        s_axil_bready <= 1'b0;
                        wr_done_o     <= 1'b1;
                        if (s_axil_bresp != 2'b00) begin
                            resp_err_o[NR] <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_regrw_mc.sv
// Scoreboard bench for dma_regrw_mc: directed stimulus queues expected
// AXI/status events, a monitor pops and compares them as they appear.
module tb_dma_regrw_mc;

    localparam int NUM_CHN = 4;
    localparam int NR      = 2 * NUM_CHN;

    localparam int K_AR   = 0;
    localparam int K_UPD  = 1;
    localparam int K_WR   = 2;
    localparam int K_DONE = 3;

    logic usr_clk = 1'b0;
    logic usr_rst;
    logic [31:0] awaddr;  logic [2:0] awprot; logic awvalid; logic awready;
    logic [31:0] wdata;   logic [3:0] wstrb;  logic wvalid;  logic wready;
    logic [1:0]  bresp;   logic bvalid;       logic bready;
    logic [31:0] araddr;  logic [2:0] arprot; logic arvalid; logic arready;
    logic [31:0] rdata;   logic [1:0] rresp;  logic rvalid;  logic rready;
    logic [NR-1:0]          run;
    logic                   wr_req;
    logic [15:0]            wr_addr;
    logic [31:0]            wr_data;
    logic                   wr_done;
    logic [NUM_CHN*32-1:0]  c2h_stts;
    logic [NUM_CHN*32-1:0]  h2c_stts;
    logic [NR-1:0]          stts_upd;
    logic [NR:0]            resp_err;

    dma_regrw_mc #(.NUM_CHN(NUM_CHN), .STTS_OFS(8'h40)) dut (
        .usr_clk(usr_clk), .usr_rst(usr_rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .dma_regrw_run_i(run), .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_done_o(wr_done), .c2h_chn_stts_o(c2h_stts), .h2c_chn_stts_o(h2c_stts),
        .stts_upd_o(stts_upd), .resp_err_o(resp_err)
    );

    always #5 usr_clk = ~usr_clk;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          idx;
    } ev_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_t;

    ev_t exp_q[$];
    rd_t rd_q[$];
    int  vec_cnt = 0;
    int  err_cnt = 0;
    int  aw_hi = 0;
    int  w_hi = 0;

    // slave behaviour knobs
    int ar_dly = 0, r_dly = 0, r_early = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0] b_resp = 2'b00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vec_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic ex(input int kind, input logic [31:0] addr, input logic [31:0] data, input int idx);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.idx = idx;
        exp_q.push_back(e);
    endtask

    task automatic rd_push(input logic [31:0] d, input logic [1:0] r);
        rd_q.push_back({d, r});
    endtask

    task automatic take(input int kind);
        ev_t e;
        logic [31:0] reg_val;
        if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_event: actual kind %0d required none", kind);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 64'(kind), 64'(e.kind));
            if (kind == K_AR) begin
                check("araddr", {32'd0, araddr}, {32'd0, e.addr});
                check("arprot", {61'd0, arprot}, 64'd0);
            end else if (kind == K_WR) begin
                check("awaddr", {32'd0, awaddr}, {32'd0, e.addr});
                check("wdata", {32'd0, wdata}, {32'd0, e.data});
                check("wstrb", {60'd0, wstrb}, 64'hf);
            end else if (kind == K_UPD) begin
                check("stts_upd", {56'd0, stts_upd}, 64'(1) << e.idx);
                if (e.idx < NUM_CHN) reg_val = c2h_stts[32*e.idx +: 32];
                else                 reg_val = h2c_stts[32*(e.idx-NUM_CHN) +: 32];
                check("stts_reg", {32'd0, reg_val}, {32'd0, e.data});
            end
        end
    endtask

    // Monitor: samples mid-low-phase, so valid&ready means a handshake at the next edge
    initial begin
        forever begin
            @(negedge usr_clk);
            #2;
            if (arvalid && arready) take(K_AR);
            if (awvalid && awready) take(K_WR);
            if (stts_upd != '0)     take(K_UPD);
            if (wr_done)            take(K_DONE);
            if (awvalid) aw_hi++;
            if (wvalid)  w_hi++;
            if (bready)  check("b_after_aw_w", {62'd0, awvalid, wvalid}, 64'd0);
        end
    end

    // AXI read slave
    initial begin
        rd_t d;
        int  n;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
        forever begin
            @(negedge usr_clk);
            if (arvalid === 1'b1) begin
                if (rd_q.size() != 0) d = rd_q.pop_front();
                else                  d = {32'd0, 2'b00};
                repeat (ar_dly) @(negedge usr_clk);
                arready = 1'b1;
                if (r_early != 0) begin
                    rvalid = 1'b1; rdata = d.data; rresp = d.resp;
                end
                @(negedge usr_clk);
                arready = 1'b0;
                if (r_early == 0) begin
                    repeat (r_dly) @(negedge usr_clk);
                    rvalid = 1'b1; rdata = d.data; rresp = d.resp;
                end
                n = 0;
                while (!rready && n < 5) begin
                    @(negedge usr_clk);
                    n++;
                end
                if (rready) @(negedge usr_clk);
                rvalid = 1'b0; rdata = '0; rresp = '0;
            end
        end
    end

    // AXI write slave
    initial begin
        int n;
        bit aw_dn, w_dn, hs_aw, hs_w;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
        forever begin
            @(negedge usr_clk);
            if (awvalid === 1'b1) begin
                n = 0; aw_dn = 0; w_dn = 0;
                while (!(aw_dn && w_dn) && n < 40) begin
                    awready = !aw_dn && (n >= aw_dly);
                    wready  = !w_dn && (n >= w_dly);
                    hs_aw   = awready && awvalid;
                    hs_w    = wready && wvalid;
                    @(negedge usr_clk);
                    if (hs_aw) aw_dn = 1;
                    if (hs_w)  w_dn = 1;
                    n++;
                end
                awready = 1'b0; wready = 1'b0;
                repeat (b_dly) @(negedge usr_clk);
                bvalid = 1'b1; bresp = b_resp;
                n = 0;
                while (!bready && n < 20) begin
                    @(negedge usr_clk);
                    n++;
                end
                if (bready) @(negedge usr_clk);
                bvalid = 1'b0; bresp = '0;
            end
        end
    end

    task automatic do_reset();
        usr_rst = 1'b1;
        repeat (2) @(negedge usr_clk);
        usr_rst = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(negedge usr_clk);
            n++;
        end
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL %s_timeout: actual %0d events outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge usr_clk);
    endtask

    // sel 0: wait for rready, sel 1: wait for awvalid
    task automatic wait_sig(input int sel, input int maxc, input string name);
        int n = 0;
        while (n < maxc) begin
            if ((sel == 0 && rready) || (sel == 1 && awvalid)) break;
            @(negedge usr_clk);
            n++;
        end
        vec_cnt++;
        if (n >= maxc) begin
            err_cnt++;
            $display("FAIL %s_wait: actual timeout after %0d cycles required signal high", name, n);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid_ready"}, {59'd0, arvalid, rready, awvalid, wvalid, bready}, 64'd0);
        check({tag, "_stts_upd"}, {56'd0, stts_upd}, 64'd0);
        check({tag, "_wr_done"}, {63'd0, wr_done}, 64'd0);
        check({tag, "_resp_err"}, {55'd0, resp_err}, 64'd0);
        check({tag, "_stts_regs"}, {63'd0, (|c2h_stts) | (|h2c_stts)}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        usr_rst = 1'b1; run = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        @(negedge usr_clk);
        do_reset();
        check_idle_outputs("reset");

        // Single C2H0 read, arready and rvalid together; latency of arvalid
        ar_dly = 0; r_early = 1; r_dly = 0;
        rd_push(32'hA5A5_0001, 2'b00);
        ex(K_AR, 32'h0000_1040, 32'h0, 0);
        ex(K_UPD, 32'h0, 32'hA5A5_0001, 0);
        run[0] = 1'b1;
        @(negedge usr_clk);
        check("arvalid_after_E0", {63'd0, arvalid}, 64'd0);
        run[0] = 1'b0;
        @(negedge usr_clk);
        check("arvalid_after_E1", {63'd0, arvalid}, 64'd1);
        wait_idle(30, "c2h0");
        check("c2h0_stts", {32'd0, c2h_stts[31:0]}, 64'hA5A5_0001);

        // Two simultaneous edges from pointer 0, then order proving pointer = 6
        r_early = 0;
        do_reset();
        rd_push(32'h2222_0002, 2'b00);
        rd_push(32'h5555_0005, 2'b00);
        ex(K_AR, 32'h0000_1240, 32'h0, 0);
        ex(K_UPD, 32'h0, 32'h2222_0002, 2);
        ex(K_AR, 32'h0000_0140, 32'h0, 0);
        ex(K_UPD, 32'h0, 32'h5555_0005, 5);
        run[5] = 1'b1; run[2] = 1'b1;
        wait_idle(60, "rr_pair");
        check("c2h2_stts", {32'd0, c2h_stts[95:64]}, 64'h2222_0002);
        check("h2c1_stts", {32'd0, h2c_stts[63:32]}, 64'h5555_0005);
        run = '0;
        @(negedge usr_clk);
        rd_push(32'h6666_0006, 2'b00);
        rd_push(32'h5555_1005, 2'b00);
        ex(K_AR, 32'h0000_0240, 32'h0, 0);
        ex(K_UPD, 32'h0, 32'h6666_0006, 6);
        ex(K_AR, 32'h0000_0140, 32'h0, 0);
        ex(K_UPD, 32'h0, 32'h5555_1005, 5);
        run[5] = 1'b1; run[6] = 1'b1;
        wait_idle(60, "rr_ptr6");
        run = '0;

        // Write and a new read edge arrive during R: write wins after R
        r_dly = 4;
        rd_push(32'h3333_0003, 2'b00);
        rd_push(32'h1111_0001, 2'b00);
        ex(K_AR, 32'h0000_1340, 32'h0, 0);
        ex(K_UPD, 32'h0, 32'h3333_0003, 3);
        ex(K_WR, 32'h0000_0008, 32'h0000_0001, 0);
        ex(K_DONE, 32'h0, 32'h0, 0);
        ex(K_AR, 32'h0000_1140, 32'h0, 0);
        ex(K_UPD, 32'h0, 32'h1111_0001, 1);
        run[3] = 1'b1;
        @(negedge usr_clk);
        run[3] = 1'b0;
        wait_sig(0, 20, "rready_t3");
        wr_req = 1'b1; wr_addr = 16'h0008; wr_data = 32'h1; run[1] = 1'b1;
        wait_sig(1, 30, "awvalid_t3");
        wr_req = 1'b0; run[1] = 1'b0;
        wait_idle(60, "wr_prio");

        // Write with awready 3 cycles behind wready and an error response
        r_dly = 0; aw_dly = 3; w_dly = 0; b_resp = 2'b10;
        ex(K_WR, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        ex(K_DONE, 32'h0, 32'h0, 0);
        aw_hi = 0; w_hi = 0;
        wr_req = 1'b1; wr_addr = 16'h0010; wr_data = 32'hDEAD_BEEF;
        wait_sig(1, 20, "awvalid_t4");
        wr_req = 1'b0;
        wait_idle(40, "wr_split");
        check("awvalid_cycles", 64'(aw_hi), 64'd4);
        check("wvalid_cycles", 64'(w_hi), 64'd1);
        check("werr_flag", {55'd0, resp_err}, 64'h100);
        aw_dly = 0; b_resp = 2'b00;

        // Read error on H2C0: flag set, data still loaded
        rd_push(32'h0BAD_0004, 2'b10);
        ex(K_AR, 32'h0000_0040, 32'h0, 0);
        ex(K_UPD, 32'h0, 32'h0BAD_0004, 4);
        run[4] = 1'b1;
        @(negedge usr_clk);
        run[4] = 1'b0;
        wait_idle(30, "rd_err");
        check("rerr_flags", {55'd0, resp_err}, 64'h110);

        // Edge on the bit being serviced re-queues it; error flags stay sticky
        r_dly = 2;
        rd_push(32'hC0C0_0010, 2'b00);
        rd_push(32'hC0C0_0020, 2'b00);
        ex(K_AR, 32'h0000_1040, 32'h0, 0);
        ex(K_UPD, 32'h0, 32'hC0C0_0010, 0);
        ex(K_AR, 32'h0000_1040, 32'h0, 0);
        ex(K_UPD, 32'h0, 32'hC0C0_0020, 0);
        run[0] = 1'b1;
        @(negedge usr_clk);
        run[0] = 1'b0;
        wait_sig(0, 20, "rready_t6");
        run[0] = 1'b1;
        @(negedge usr_clk);
        run[0] = 1'b0;
        wait_idle(40, "requeue");
        check("err_sticky", {55'd0, resp_err}, 64'h110);

        // Reset while waiting for rvalid: transaction discarded
        r_dly = 3;
        rd_push(32'h7777_0007, 2'b00);
        ex(K_AR, 32'h0000_0340, 32'h0, 0);
        run[7] = 1'b1;
        @(negedge usr_clk);
        run[7] = 1'b0;
        wait_sig(0, 20, "rready_t7");
        usr_rst = 1'b1;
        @(negedge usr_clk);
        usr_rst = 1'b0;
        check_idle_outputs("mid_r_reset");
        repeat (12) @(negedge usr_clk);
        check("no_late_update", {63'd0, (|c2h_stts) | (|h2c_stts)}, 64'd0);
        wait_idle(5, "final");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
